// File: rtl/edib_tx_sched.sv
// edib_tx_sched: round-robin scheduler for the shared EDIB M2 transmit channel.
// Each frame latches the winning requester's word, pulses tx_start, waits for
// tx_done (bounded by TIMEOUT_CYC), then enforces GAP_CYC idle cycles.
// Optional build macro: EDIB_TX_PRIO0_EN gives requester 0 strict priority
// over the round-robin pool.
//
// Handshake: req[i] is a level acting as "valid". It is held high until the
// one-cycle done[i] pulse, which acts as the "ready/accepted" return. A req
// still high after its done is treated as a fresh request. The transmitter
// side is tx_start (one-cycle command) answered by tx_done (one-cycle
// completion), and tx_done is only honoured while a frame is in WAIT.
module edib_tx_sched #(
   parameter int NREQ        = 3,
   parameter int TIMEOUT_CYC = 1024,
   parameter int GAP_CYC     = 4
) (
   input  logic                dsp_clkout,
   input  logic                reset,
   input  logic [NREQ-1:0]     req,
   input  logic [16*NREQ-1:0]  req_data,
   output logic [NREQ-1:0]     done,
   output logic [15:0]         tx_data,
   output logic                tx_start,
   input  logic                tx_done,
   output logic                busy,
   output logic [2:0]          cur_id,
   output logic                timeout_err,
   input  logic                clr_err,
   output logic [1:0]          state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   localparam int TW       = $clog2(TIMEOUT_CYC);
   localparam int GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

   state_t          state;
   state_t          state_nxt;
   logic [TW-1:0]   timer;
   logic [GW-1:0]   gap_cnt;
   logic [2:0]      last_ptr;
   logic            grant_valid;
   logic [2:0]      grant_id;
   logic            timer_hit;
   logic            frame_end;
   logic            timeout_hit;

   assign timer_hit   = (timer == TW'(TIMEOUT_CYC - 1));
   // tx_done has precedence over an expiry in the same cycle.
   assign frame_end   = (state == S_WAIT) && (tx_done || timer_hit);
   assign timeout_hit = (state == S_WAIT) && !tx_done && timer_hit;
   assign busy        = (state != S_IDLE);
   assign state_dbg   = state;

   // Arbiter: first request found scanning upward from the slot after the
   // last one served, wrapping; optionally requester 0 overrides the scan.
   always_comb begin
      int idx;
      grant_valid = 1'b0;
      grant_id    = 3'd0;
      idx         = 0;
      for (int off = 1; off <= NREQ; off++) begin
         idx = (int'(last_ptr) + off) % NREQ;
         if (!grant_valid && req[idx]) begin
            grant_valid = 1'b1;
            grant_id    = 3'(idx);
         end
      end
`ifdef EDIB_TX_PRIO0_EN
      if (req[0]) begin
         grant_valid = 1'b1;
         grant_id    = 3'd0;
      end
`else
`endif
   end

   // State register.
   always_ff @(posedge dsp_clkout) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic for the frame sequence.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (grant_valid) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT:  if (frame_end) state_nxt = (GAP_CYC == 0) ? S_IDLE : S_GAP;
         S_GAP:   if (gap_cnt == GW'(GAP_LAST)) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Frame datapath: latched word/id, start and done pulses, timers, pointer.
   always_ff @(posedge dsp_clkout) begin
      if (reset) begin
         tx_data     <= 16'h0000;
         cur_id      <= 3'd0;
         tx_start    <= 1'b0;
         done        <= '0;
         timer       <= '0;
         gap_cnt     <= '0;
         last_ptr    <= 3'(NREQ - 1);
         timeout_err <= 1'b0;
      end else begin
         tx_start <= (state == S_ISSUE);
         done     <= '0;
         if (frame_end) begin
            done     <= {{(NREQ-1){1'b0}}, 1'b1} << cur_id;
            last_ptr <= cur_id;
         end
         if (state == S_IDLE && grant_valid) begin
            cur_id  <= grant_id;
            tx_data <= req_data[16*int'(grant_id) +: 16];
         end
         if (state == S_ISSUE)     timer <= '0;
         else if (state == S_WAIT) timer <= timer + 1'b1;
         if (state == S_WAIT)      gap_cnt <= '0;
         else if (state == S_GAP)  gap_cnt <= gap_cnt + 1'b1;
         // A new timeout outranks a simultaneous clear.
         if (timeout_hit)  timeout_err <= 1'b1;
         else if (clr_err) timeout_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_edib_tx_sched.sv
// Bench for edib_tx_sched: directed scenarios followed by randomized traffic,
// each frame checked against a scoreboard filled by a round-robin model.
module tb_edib_tx_sched;

   localparam int NREQ = 3;
   localparam int TO   = 16;
   localparam int GAP  = 4;
   localparam int W    = 19;

   logic                dsp_clkout;
   logic                reset;
   logic [NREQ-1:0]     req;
   logic [16*NREQ-1:0]  req_data;
   logic [NREQ-1:0]     done;
   logic [15:0]         tx_data;
   logic                tx_start;
   logic                tx_done;
   logic                busy;
   logic [2:0]          cur_id;
   logic                timeout_err;
   logic                clr_err;
   logic [1:0]          state_dbg;

   logic [15:0]   data_arr [NREQ];
   logic [W-1:0]  exp_q [$];
   int            n_checks = 0;
   int            n_pass   = 0;
   int            mdl_last = NREQ - 1;
   int            cyc      = 0;
   int            last_wait;
   int            start_cyc;

   assign req_data = {data_arr[2], data_arr[1], data_arr[0]};

   edib_tx_sched #(.NREQ(NREQ), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)) dut (
      .dsp_clkout  (dsp_clkout),
      .reset       (reset),
      .req         (req),
      .req_data    (req_data),
      .done        (done),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .tx_done     (tx_done),
      .busy        (busy),
      .cur_id      (cur_id),
      .timeout_err (timeout_err),
      .clr_err     (clr_err),
      .state_dbg   (state_dbg)
   );

   // Clock and cycle counter.
   initial begin
      dsp_clkout = 1'b0;
      forever #5 dsp_clkout = ~dsp_clkout;
   end
   always @(posedge dsp_clkout) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge dsp_clkout);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
   endtask

   function automatic logic [NREQ-1:0] onehot(input logic [2:0] id);
      return NREQ'(1) << id;
   endfunction

   // Reference arbitration: build the visiting order starting after the last
   // served requester and take the first one asking.
   function automatic logic [2:0] mdl_winner(input logic [NREQ-1:0] r);
      int order[$];
      logic [2:0] w;
      bit found;
      w = 3'd0;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) order.push_back((mdl_last + k) % NREQ);
      foreach (order[j]) begin
         if (!found && r[order[j]]) begin
            w = 3'(order[j]);
            found = 1'b1;
         end
      end
`ifdef EDIB_TX_PRIO0_EN
      if (r[0]) w = 3'd0;
`else
`endif
      return w;
   endfunction

   task automatic predict();
      logic [2:0] w;
      w = mdl_winner(req);
      exp_q.push_back({w, data_arr[w]});
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      req     = '0;
      tx_done = 1'b0;
      clr_err = 1'b0;
      tick();
      tick();
      reset    = 1'b0;
      mdl_last = NREQ - 1;
   endtask

   // Wait for the next tx_start and check the frame it carries.
   task automatic wait_start(output logic [W-1:0] e);
      int n;
      e = exp_q.pop_front();
      n = 0;
      while (tx_start !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      last_wait = n;
      start_cyc = cyc;
      chk("tx_start_seen", tx_start, 1);
      chk("cur_id", cur_id, e[18:16]);
      chk("tx_data", tx_data, e[15:0]);
      chk("busy_in_frame", busy, 1);
   endtask

   // Serve one frame: tx_done lat cycles after tx_start (or never).
   task automatic do_frame(input int lat, input bit no_done, input bit drop, input bit exp_err);
      logic [W-1:0] e;
      int done_at;
      wait_start(e);
      tick();
      chk("tx_start_width", tx_start, 0);
      done_at = no_done ? TO : lat + 1;
      for (int c = 1; c < done_at; c++) begin
         chk("done_early", done, 0);
         chk("tx_data_stable", tx_data, e[15:0]);
         if (!no_done && c == done_at - 1) tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
      end
      chk("done_pulse", done, onehot(e[18:16]));
      chk("timeout_err", timeout_err, exp_err);
      mdl_last = int'(e[18:16]);
      if (drop) req[e[18:16]] = 1'b0;
      tick();
      chk("done_width", done, 0);
   endtask

   initial begin
      logic [W-1:0] e;
      logic [NREQ-1:0] newb;
      int prev_start;
      foreach (data_arr[i]) data_arr[i] = 16'h0;

      // Reset values.
      reset = 1'b1; req = '0; tx_done = 1'b0; clr_err = 1'b0;
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_data", tx_data, 16'h0000);
      chk("rst_cur_id", cur_id, 0);
      chk("rst_timeout_err", timeout_err, 0);
      tick();
      reset = 1'b0;
      mdl_last = NREQ - 1;

      // Single request from requester 1.
      data_arr[1] = 16'hA55A;
      req = 3'b010;
      predict();
      do_frame(5, 1'b0, 1'b1, 1'b0);
      chk("latency_req_to_start", last_wait, 2);

      // All requesters at once, two rounds.
      do_reset();
      for (int i = 0; i < NREQ; i++) data_arr[i] = 16'($urandom);
      prev_start = -100;
      for (int round = 0; round < 2; round++) begin
         req = 3'b111;
         for (int f = 0; f < NREQ; f++) begin
            predict();
            chk("rr_order", exp_q[0][18:16], f);
            do_frame(1, 1'b0, 1'b1, 1'b0);
            if (prev_start >= 0)
               chk("frame_spacing", (start_cyc - prev_start >= 3 + GAP), 1);
            prev_start = start_cyc;
         end
      end

      // Timeout with no tx_done, then clear and a normal frame.
      req = 3'b001;
      predict();
      do_frame(0, 1'b1, 1'b1, 1'b1);
      tick();
      chk("err_sticky", timeout_err, 1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("err_cleared", timeout_err, 0);
      req = 3'b010;
      predict();
      do_frame(3, 1'b0, 1'b1, 1'b0);

      // Clear held across a timeout: setting wins.
      clr_err = 1'b1;
      req = 3'b100;
      predict();
      do_frame(0, 1'b1, 1'b1, 1'b1);
      chk("err_cleared_after_set", timeout_err, 0);
      clr_err = 1'b0;

      // tx_done exactly in the expiry cycle.
      req = 3'b001;
      predict();
      do_frame(TO - 1, 1'b0, 1'b1, 1'b0);

      // Reset in the middle of WAIT.
      tick(); tick(); tick();
      req = 3'b001;
      predict();
      wait_start(e);
      tick(); tick(); tick();
      reset = 1'b1;
      req = 3'b100;
      tick();
      reset = 1'b0;
      mdl_last = NREQ - 1;
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_tx_start", tx_start, 0);
      chk("rst_mid_done", done, 0);
      tick();
      chk("rst_mid_no_done", done, 0);
      predict();
      chk("rst_mid_winner", exp_q[0][18:16], 2);
      do_frame(4, 1'b0, 1'b1, 1'b0);

      // Requesters 0 and 2 both held high continuously.
      do_reset();
      data_arr[0] = 16'h0D5F;
      data_arr[2] = 16'h7E57;
      req = 3'b101;
      for (int f = 0; f < 4; f++) begin
         predict();
         do_frame(2, 1'b0, 1'b0, 1'b0);
      end

      // Randomized traffic.
      do_reset();
      for (int f = 0; f < 14; f++) begin
         if (req == '0) begin
            newb = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) if (newb[i]) data_arr[i] = 16'($urandom);
            req = newb;
         end
         predict();
         do_frame($urandom_range(1, 12), 1'b0, 1'b1, 1'b0);
         newb = NREQ'($urandom_range(0, (1 << NREQ) - 1)) & ~req;
         for (int i = 0; i < NREQ; i++) if (newb[i]) data_arr[i] = 16'($urandom);
         req = req | newb;
         if ($urandom_range(0, 1) == 1) begin
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            chk("stray_tx_done_ignored", done, 0);
         end
      end
      req = '0;
      for (int i = 0; i < 30 && busy; i++) tick();
      chk("final_idle", busy, 0);
      chk("final_err", timeout_err, 0);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
